// File: rtl/exec_pkg.sv
// Shared types and constants for the execute-stage sequencer and its datapath interface.
package exec_pkg;

    localparam int CTRL_W_DEF     = 6;
    localparam int TAG_W_DEF      = 4;
    localparam int MC_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_WAIT = 2'd1,
        EXEC    = 2'd2
    } exec_state_e;

    typedef enum logic [CTRL_W_DEF-1:0] {
        ALU_NOP = 6'h00,
        ALU_AND = 6'h01,
        ALU_ADD = 6'h02,
        ALU_SUB = 6'h03,
        ALU_OR  = 6'h04,
        ALU_XOR = 6'h05,
        ALU_SLT = 6'h08,
        ALU_MUL = 6'h10,
        ALU_DIV = 6'h11,
        ALU_REM = 6'h12
    } alu_ctrl_e;

    // Destination state for a freshly captured op.
    function automatic exec_state_e dispatch_state(input logic multicycle);
        exec_state_e st;
        if (multicycle) begin
            st = MC_WAIT;
        end else begin
            st = EXEC;
        end
        return st;
    endfunction

endpackage

// File: rtl/exec_stage_ctrl_if.sv
// Decode-side op handshake and writeback-side result handshake of the execute stage.
interface exec_stage_ctrl_if
    import exec_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
);

    logic              id_valid;
    logic              id_ready;
    logic [CTRL_W-1:0] id_alu_ctrl;
    logic              id_branch;
    logic              id_multicycle;
    logic [TAG_W-1:0]  id_tag;
    logic              wb_valid;
    logic              wb_ready;
    logic [TAG_W-1:0]  wb_tag;

    modport master (
        output id_valid, id_alu_ctrl, id_branch, id_multicycle, id_tag, wb_ready,
        input  id_ready, wb_valid, wb_tag
    );

    modport slave (
        input  id_valid, id_alu_ctrl, id_branch, id_multicycle, id_tag, wb_ready,
        output id_ready, wb_valid, wb_tag
    );

endinterface

// File: rtl/exec_mc_timer.sv
// Watchdog for the shared multi-cycle unit: counts cycles spent waiting and flags the last allowed one.
module exec_mc_timer
    import exec_pkg::*;
#(
    parameter int MC_TIMEOUT = MC_TIMEOUT_DEF
)(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    logic [CNT_W-1:0] count_r;

    // Wait counter; saturates on the last cycle so it never wraps back into range.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && !expired) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == CNT_W'(MC_TIMEOUT - 1));

endmodule

// File: rtl/exec_stage_ctrl.sv
// Execute-stage sequencer: accepts decoded ops, drives ALU control, tracks the mul/div unit,
// holds results under writeback backpressure and flushes on taken branches.
module exec_stage_ctrl
    import exec_pkg::*;
#(
    parameter int CTRL_W     = CTRL_W_DEF,
    parameter int TAG_W      = TAG_W_DEF,
    parameter int MC_TIMEOUT = MC_TIMEOUT_DEF
)(
    input  logic               clock,
    input  logic               reset,
    exec_stage_ctrl_if.slave   id_wb,
    output logic               ex_capture,
    output logic [CTRL_W-1:0]  ex_alu_ctrl,
    output logic               ex_branch_op,
    output logic               mc_start,
    input  logic               mc_done,
    input  logic               jump_flag,
    output logic               flush,
    output logic               busy,
    output logic               timeout_err
);

    exec_state_e       state_r;
    exec_state_e       state_s;
    logic              ready_en_r;
    logic              mc_start_r;
    logic              timeout_r;
    logic              branch_r;
    logic [CTRL_W-1:0] alu_ctrl_r;
    logic [TAG_W-1:0]  tag_r;

    logic id_ready_s;
    logic capture_s;
    logic flush_s;
    logic wb_valid_s;
    logic busy_s;
    logic mc_done_s;
    logic tmr_clear_s;
    logic tmr_enable_s;
    logic tmr_expired_s;

    // A done seen in the start cycle belongs to an earlier request and is ignored.
    assign mc_done_s    = mc_done & ~mc_start_r;
    assign tmr_clear_s  = capture_s & id_wb.id_multicycle;
    assign tmr_enable_s = (state_r == MC_WAIT);

    exec_mc_timer #(
        .MC_TIMEOUT (MC_TIMEOUT)
    ) u_mc_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmr_clear_s),
        .enable  (tmr_enable_s),
        .expired (tmr_expired_s)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake and flush decode; capture is suppressed when the held branch flushes.
    always_comb begin
        id_ready_s = 1'b0;
        flush_s    = 1'b0;
        wb_valid_s = 1'b0;
        busy_s     = 1'b1;
        case (state_r)
            IDLE: begin
                id_ready_s = ready_en_r;
                busy_s     = 1'b0;
            end
            MC_WAIT: begin
                id_ready_s = 1'b0;
            end
            EXEC: begin
                wb_valid_s = 1'b1;
                id_ready_s = id_wb.wb_ready;
                flush_s    = id_wb.wb_ready & branch_r & jump_flag;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
        capture_s = id_wb.id_valid & id_ready_s & ~flush_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (capture_s) begin
                    state_s = dispatch_state(id_wb.id_multicycle);
                end else begin
                    state_s = IDLE;
                end
            end
            MC_WAIT: begin
                if (mc_done_s || tmr_expired_s) begin
                    state_s = EXEC;
                end else begin
                    state_s = MC_WAIT;
                end
            end
            EXEC: begin
                if (!id_wb.wb_ready) begin
                    state_s = EXEC;
                end else if (capture_s) begin
                    state_s = dispatch_state(id_wb.id_multicycle);
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Op control registered on capture and held for the datapath and writeback.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_ctrl_r <= {CTRL_W{1'b0}};
            branch_r   <= 1'b0;
            tag_r      <= {TAG_W{1'b0}};
        end else if (capture_s) begin
            alu_ctrl_r <= id_wb.id_alu_ctrl;
            branch_r   <= id_wb.id_branch;
            tag_r      <= id_wb.id_tag;
        end else begin
            alu_ctrl_r <= alu_ctrl_r;
            branch_r   <= branch_r;
            tag_r      <= tag_r;
        end
    end

    // Start pulse, post-reset ready enable and sticky timeout flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_en_r <= 1'b0;
            mc_start_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            mc_start_r <= capture_s & id_wb.id_multicycle;
            if ((state_r == MC_WAIT) && !mc_done_s && tmr_expired_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign id_wb.id_ready = id_ready_s;
    assign id_wb.wb_valid = wb_valid_s;
    assign id_wb.wb_tag   = tag_r;
    assign ex_capture     = capture_s;
    assign ex_alu_ctrl    = alu_ctrl_r;
    assign ex_branch_op   = branch_r;
    assign mc_start       = mc_start_r;
    assign flush          = flush_s;
    assign busy           = busy_s;
    assign timeout_err    = timeout_r;

endmodule
